avalon_mem_arbiter: RTL and testbench
=====================================

# avalon_mem_arbiter

- Shares one Avalon-MM memory slave between the CPU's instruction-fetch port and its data port.
- The slave is the single-ported, variable-latency memory with `waitrequest`.
- Arbitration is registered and round-robin. Exactly one transaction is in flight at a time.
- A watchdog flags a slave that stalls too long.
- Sits between the MIPS core's two bus masters and the memory/bus top level.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: stall cycles in BUSY before `timeout_err` sets. Legal range is 1..65535.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `i_read`, in, 1: instruction port read request.
- `i_addr`, in, 32: instruction byte address.
- `i_waitrequest`, out, 1: stall to the instruction port.
- `i_readdata`, out, 32: read data to the instruction port.
- `d_read`, in, 1: data port read request.
- `d_write`, in, 1: data port write request.
- `d_addr`, in, 32: data byte address.
- `d_byteenable`, in, 4: data byte enables.
- `d_writedata`, in, 32: data write value.
- `d_waitrequest`, out, 1: stall to the data port.
- `d_readdata`, out, 32: read data to the data port.
- `m_read`, out, 1: read request to the slave.
- `m_write`, out, 1: write request to the slave.
- `m_addr`, out, 32: address to the slave.
- `m_byteenable`, out, 4: byte enables to the slave.
- `m_writedata`, out, 32: write data to the slave.
- `m_readdata`, in, 32: read data from the slave.
- `m_waitrequest`, in, 1: stall from the slave.
- `timeout_err`, out, 1: sticky watchdog error flag.

## Operation
States are IDLE, BUSY and RESP. `owner` is I or D. `last` is the most recently granted port.

- **IDLE**
  - `m_read` = `m_write` = 0, `m_addr`/`m_byteenable`/`m_writedata` = 0.
  - `i_waitrequest` = `d_waitrequest` = 1.
  - A port's request is `i_read`, or `d_read|d_write`.
  - If any request is present: go to BUSY with `owner` = the requester.
  - If both request: `owner` = the port that is not `last`. Set `last` = `owner`.
- **BUSY**
  - `m_*` mirror the owner's signals. For owner I: `m_write` = 0 and `m_byteenable` = 4'hF.
  - Owner's waitrequest = `m_waitrequest`. The other port's waitrequest = 1.
  - If `d_read` and `d_write` are both high: write wins, `m_read` = 0.
  - Edge with `m_waitrequest`=0 and the owner requesting:
    - a read goes to RESP;
    - a write goes to IDLE.
  - If the owner drops its request before acceptance, go to IDLE with no transfer (protocol violation tolerated).
- **RESP**
  - One cycle. `m_read` = `m_write` = 0, both waitrequests = 1.
  - The slave's registered `readdata` is valid this cycle.
  - Then go to IDLE.
- **Read data:** `i_readdata` = `d_readdata` = `m_readdata` at all times (broadcast). Only the owner samples, in RESP.
- **Watchdog**
  - Counter clears on entry to BUSY.
  - Increments each BUSY cycle with `m_waitrequest`=1, saturating.
  - When it equals `TIMEOUT_CYCLES`, `timeout_err` sets and stays set until reset.
  - The transaction is not aborted.

## Timing
- **Reset values:** state IDLE, `last` = I (so D wins the first tie), counter 0, `timeout_err` 0, all `m_*` 0, both waitrequests 1.
- **Reset mid-transaction:** immediate return to IDLE. The lost transfer is not replayed.
- **Arbitration latency:** a request first high in cycle n is presented on `m_*` in cycle n+1.
- **Minimum transaction:** 1 IDLE + 1 BUSY cycle for a write. Reads add 1 RESP cycle.
- **Back-to-back:** a port requesting again goes through IDLE, giving at least one idle bus cycle between transactions.
- **Both ports continuously requesting:** grants strictly alternate D, I, D, I…
- **Master obligation:** signals are held stable while its waitrequest is 1. The arbiter relies on this and does not register `m_addr`/`m_writedata`.
- **Slave `m_waitrequest` in IDLE/RESP:** ignored.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum (IDLE, BUSY, RESP);
  - `owner_t` enum (OWN_I, OWN_D);
  - `WATCHDOG_W` = 16.
- Sub-module `bus_watchdog`: clear/count/saturate counter plus sticky flag, parameterised by `TIMEOUT_CYCLES`.
- The top module holds the FSM, the `last` register and the output muxing.

## Test plan
- **Single I read:** `i_read`=1, `i_addr`=BFC00000; slave word 0 = 0x2402000A; slave stalls 2 cycles.
  - Expect `m_read` high from cycle 1.
  - Expect `i_waitrequest` to follow the slave.
  - Expect RESP with `i_readdata`=0x2402000A; `d_waitrequest` held 1 throughout.
- **D write with byte enables:** `d_write`=1, `d_byteenable`=4'b0011, `d_writedata`=0xAABBCCDD, addr BFC00004.
  - Expect one accepted write, then IDLE.
  - A readback at BFC00004 returns only the enabled bytes changed.
- **Simultaneous requests from reset:** both request.
  - Expect grants D, I, D, I over four transactions.
  - Expect an IDLE cycle between each.
- **Owner drops request in BUSY:**
  - Expect return to IDLE.
  - Expect no accepted transfer at the slave.
  - The other port is granted next.
- **Watchdog:** `TIMEOUT_CYCLES`=8; slave holds waitrequest high for 10 cycles.
  - Expect `timeout_err` rising in the 8th stall cycle and still high after completion.
  - Expect it cleared only by `reset_n`.
- **Async reset in BUSY:** pulse `reset_n` low mid-stall.
  - Expect IDLE, `m_read`=0 and both waitrequests=1 without a clock edge.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data Avalon-MM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int WATCHDOG_W = 16;

    // Round-robin pick: a lone requester wins, a tie goes to the port that was not granted last.
    function automatic owner_t rr_pick(input logic i_req, input logic d_req, input owner_t last);
        owner_t pick;
        if (i_req && d_req) begin
            pick = (last == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            pick = OWN_D;
        end else begin
            pick = OWN_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Stall watchdog: counts BUSY cycles the slave holds waitrequest and raises a
// sticky error once the count reaches TIMEOUT_CYCLES. Never aborts the transfer.
module bus_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic stall,
    output logic timeout_err
);

    localparam logic [WATCHDOG_W-1:0] TIMEOUT_VAL = WATCHDOG_W'(TIMEOUT_CYCLES);
    localparam logic [WATCHDOG_W-1:0] CNT_MAX     = {WATCHDOG_W{1'b1}};

    logic [WATCHDOG_W-1:0] stall_cnt;
    logic [WATCHDOG_W-1:0] cnt_next;

    // Saturating increment so a very long stall never wraps back through the threshold.
    always_comb begin
        cnt_next = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + WATCHDOG_W'(1);
    end

    // Counter clears on entry to BUSY; the flag rises on the edge that closes the
    // TIMEOUT_CYCLES-th stall cycle and then holds until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else if (clear) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= cnt_next;
            if (cnt_next == TIMEOUT_VAL) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter for the MIPS core: instruction fetch
// port (read only) and data port (read/write) share a single-ported memory with
// waitrequest. One transaction in flight, round-robin grant, stall watchdog.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | bus quiet, both masters stalled; grant taken on the next edge
//   BUSY  | owner's request mirrored to the slave until it drops waitrequest
//   RESP  | slave's registered readdata valid; owner samples it this cycle
//
// Address and write data are passed straight through: masters hold them stable
// while stalled, so no copy is kept here.
module avalon_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_writedata,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,

    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteenable,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,

    output logic        timeout_err
);

    arb_state_t state;
    owner_t     owner;
    owner_t     last;

    logic   i_req;
    logic   d_req;
    logic   owner_req;
    logic   owner_is_write;
    owner_t grant;

    // Request decode and the round-robin winner for the next grant.
    always_comb begin
        i_req          = i_read;
        d_req          = d_read | d_write;
        owner_req      = (owner == OWN_I) ? i_req : d_req;
        owner_is_write = (owner == OWN_D) && d_write;
        grant          = rr_pick(i_req, d_req, last);
    end

    // Arbitration FSM with the owner and last-grant registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            owner <= OWN_I;
            last  <= OWN_I;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state <= BUSY;
                        owner <= grant;
                        last  <= grant;
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        // Owner withdrew before acceptance: abandon without a transfer.
                        state <= IDLE;
                    end else if (!m_waitrequest) begin
                        state <= owner_is_write ? IDLE : RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Slave-side mux and master stalls; only BUSY exposes a request to the slave.
    always_comb begin
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_addr        = '0;
        m_byteenable  = '0;
        m_writedata   = '0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        if (state == BUSY) begin
            if (owner == OWN_I) begin
                m_read        = i_read;
                m_addr        = i_addr;
                m_byteenable  = 4'hF;
                i_waitrequest = m_waitrequest;
            end else begin
                // A master asserting both strobes gets a write.
                m_write       = d_write;
                m_read        = d_read & ~d_write;
                m_addr        = d_addr;
                m_byteenable  = d_byteenable;
                m_writedata   = d_writedata;
                d_waitrequest = m_waitrequest;
            end
        end
    end

    // Read data is broadcast; only the owner samples it, in RESP.
    assign i_readdata = m_readdata;
    assign d_readdata = m_readdata;

    logic wd_clear;
    logic wd_stall;

    // Watchdog restarts with every new grant and counts stalled BUSY cycles.
    always_comb begin
        wd_clear = (state == IDLE) && (i_req || d_req);
        wd_stall = (state == BUSY) && m_waitrequest;
    end

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (wd_clear),
        .stall      (wd_stall),
        .timeout_err(timeout_err)
    );

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed bench for avalon_mem_arbiter with a small stalling memory slave model.
module tb_avalon_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_read;
    logic [31:0] i_addr;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [3:0]  d_byteenable;
    logic [31:0] d_writedata;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_addr;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic        timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    avalon_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_read       (i_read),
        .i_addr       (i_addr),
        .i_waitrequest(i_waitrequest),
        .i_readdata   (i_readdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_byteenable (d_byteenable),
        .d_writedata  (d_writedata),
        .d_waitrequest(d_waitrequest),
        .d_readdata   (d_readdata),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_addr       (m_addr),
        .m_byteenable (m_byteenable),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest),
        .timeout_err  (timeout_err)
    );

    // Slave model: stalls each request for stall_len cycles, registered readdata.
    int          stall_len;
    logic [7:0]  stall_cnt;
    int          n_wr;
    logic [31:0] mem [0:15];

    assign m_waitrequest = (m_read | m_write) && (int'(stall_cnt) < stall_len);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt  <= '0;
            n_wr       <= 0;
            m_readdata <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[0] <= 32'h2402000A;
            mem[1] <= 32'h11223344;
        end else begin
            if ((m_read | m_write) && m_waitrequest) stall_cnt <= stall_cnt + 8'd1;
            else                                     stall_cnt <= '0;
            if (m_write && !m_waitrequest) begin
                for (int b = 0; b < 4; b++)
                    if (m_byteenable[b]) mem[m_addr[5:2]][b*8 +: 8] <= m_writedata[b*8 +: 8];
                n_wr <= n_wr + 1;
            end
            if (m_read && !m_waitrequest) m_readdata <= mem[m_addr[5:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int g;
    int last_c;
    int wr0;

    initial begin
        reset_n = 1'b0; i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_byteenable = '0; d_writedata = '0;
        stall_len = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_read", m_read, 1'b0);
        chk("rst_m_write", m_write, 1'b0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_be", m_byteenable, 4'h0);
        chk("rst_m_wd", m_writedata, 32'h0);
        chk("rst_i_wait", i_waitrequest, 1'b1);
        chk("rst_d_wait", d_waitrequest, 1'b1);
        chk("rst_timeout", timeout_err, 1'b0);
        reset_n = 1'b1;
        tick();

        // Single instruction read, slave stalls 2 cycles
        stall_len = 2; i_read = 1'b1; i_addr = 32'hBFC00000;
        chk("i_rd_idle", m_read, 1'b0);
        tick();
        chk("i_rd_m_read", m_read, 1'b1);
        chk("i_rd_addr", m_addr, 32'hBFC00000);
        chk("i_rd_be", m_byteenable, 4'hF);
        chk("i_rd_m_write", m_write, 1'b0);
        chk("i_rd_wait1", i_waitrequest, 1'b1);
        chk("i_rd_d_wait1", d_waitrequest, 1'b1);
        tick();
        chk("i_rd_wait2", i_waitrequest, 1'b1);
        tick();
        chk("i_rd_wait3", i_waitrequest, 1'b0);
        chk("i_rd_d_wait3", d_waitrequest, 1'b1);
        tick();
        chk("i_rd_resp_m_read", m_read, 1'b0);
        chk("i_rd_resp_wait", i_waitrequest, 1'b1);
        chk("i_rd_data", i_readdata, 32'h2402000A);
        chk("i_rd_resp_d_wait", d_waitrequest, 1'b1);
        i_read = 1'b0;
        tick();

        // Data write with byte enables, then readback
        stall_len = 0; wr0 = n_wr;
        d_write = 1'b1; d_addr = 32'hBFC00004; d_byteenable = 4'b0011; d_writedata = 32'hAABBCCDD;
        tick();
        chk("d_wr_m_write", m_write, 1'b1);
        chk("d_wr_be", m_byteenable, 4'b0011);
        chk("d_wr_wd", m_writedata, 32'hAABBCCDD);
        chk("d_wr_d_wait", d_waitrequest, 1'b0);
        chk("d_wr_i_wait", i_waitrequest, 1'b1);
        tick();
        chk("d_wr_idle_m_write", m_write, 1'b0);
        chk("d_wr_idle_d_wait", d_waitrequest, 1'b1);
        chk("d_wr_count", n_wr, wr0 + 1);
        d_write = 1'b0;
        tick();
        d_read = 1'b1;
        tick();
        chk("d_rb_m_read", m_read, 1'b1);
        tick();
        chk("d_rb_data", d_readdata, 32'h1122CCDD);
        d_read = 1'b0;
        tick();

        // Simultaneous continuous requests from reset: D, I, D, I with gaps
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        i_read = 1'b1; i_addr = 32'hBFC00010;
        d_read = 1'b1; d_addr = 32'hBFC00020;
        g = 0; last_c = 0;
        for (int c = 1; c <= 20 && g < 4; c++) begin
            tick();
            if (m_read) begin
                chk($sformatf("rr_grant%0d", g), m_addr, (g % 2 == 0) ? 32'hBFC00020 : 32'hBFC00010);
                if (g > 0) chk($sformatf("rr_gap%0d", g), c - last_c, 3);
                last_c = c;
                g++;
            end
        end
        chk("rr_grant_count", g, 4);
        i_read = 1'b0; d_read = 1'b0;
        tick();
        tick();

        // Owner drops its request mid-stall; other port granted next
        stall_len = 5; wr0 = n_wr;
        i_read = 1'b1; i_addr = 32'hBFC00000;
        d_write = 1'b1; d_addr = 32'hBFC00008; d_byteenable = 4'hF; d_writedata = 32'h55555555;
        tick();
        chk("drop_m_write", m_write, 1'b1);
        chk("drop_addr", m_addr, 32'hBFC00008);
        chk("drop_d_wait", d_waitrequest, 1'b1);
        tick();
        d_write = 1'b0;
        tick();
        chk("drop_idle_m_read", m_read, 1'b0);
        chk("drop_idle_m_write", m_write, 1'b0);
        chk("drop_idle_i_wait", i_waitrequest, 1'b1);
        chk("drop_idle_d_wait", d_waitrequest, 1'b1);
        tick();
        chk("drop_next_m_read", m_read, 1'b1);
        chk("drop_next_addr", m_addr, 32'hBFC00000);
        chk("drop_no_write", n_wr, wr0);
        for (int k = 0; k < 10 && i_waitrequest; k++) tick();
        chk("drop_i_done", i_waitrequest, 1'b0);
        tick();
        chk("drop_i_data", i_readdata, 32'h2402000A);
        i_read = 1'b0;
        tick();
        chk("drop_no_timeout", timeout_err, 1'b0);

        // Watchdog: TIMEOUT_CYCLES = 8, slave stalls 10 cycles
        stall_len = 10; i_read = 1'b1;
        tick();
        repeat (6) tick();
        chk("wd_before", timeout_err, 1'b0);
        repeat (2) tick();
        chk("wd_set", timeout_err, 1'b1);
        chk("wd_still_busy", i_waitrequest, 1'b1);
        for (int k = 0; k < 10 && i_waitrequest; k++) tick();
        chk("wd_done", i_waitrequest, 1'b0);
        tick();
        i_read = 1'b0;
        tick();
        tick();
        chk("wd_sticky", timeout_err, 1'b1);
        chk("wd_idle_m_read", m_read, 1'b0);

        // Asynchronous reset in the middle of a stall
        stall_len = 50; i_read = 1'b1;
        tick();
        tick();
        chk("ar_busy", m_read, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_m_read", m_read, 1'b0);
        chk("ar_i_wait", i_waitrequest, 1'b1);
        chk("ar_d_wait", d_waitrequest, 1'b1);
        chk("ar_timeout", timeout_err, 1'b0);
        i_read = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("ar_after_m_read", m_read, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
